// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main control FSM and the datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave side.
interface multicycle_main_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       aluop;
  logic [1:0]       pc_source;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
           pc_source, illegal, state, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
           pc_source, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: per-opcode sequencing,
// memory ready stalls and a retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | register read, branch target precompute, opcode dispatch
// MEMADR | lw/sw effective address
// MEMRD  | lw data read, waits on mem_ready
// MEMWB  | lw register writeback
// MEMWR  | sw data write, waits on mem_ready
// EXEC   | R-type ALU operation
// RCOMP  | R-type register writeback
// BRANCH | beq compare and conditional PC load
// JUMP   | jump target PC load
// ADDIEX | addi ALU operation
// ADDIWB | addi register writeback
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_main_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctl_t             ctl;
  logic             retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    ctl     = '0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
        state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            ctl.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        state_d      = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        retire         = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        retire        = bus.mem_ready;
        state_d       = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.aluop     = 2'b10;
        state_d       = S_RCOMP;
      end
      S_RCOMP: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.aluop         = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        retire            = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
        retire        = 1'b1;
      end
      S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
        retire        = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    // Reset silences the datapath within the same cycle, before the reset edge lands.
    if (!rst_n) ctl = '0;
  end

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.i_or_d        = ctl.i_or_d;
  assign bus.mem_read      = ctl.mem_read;
  assign bus.mem_write     = ctl.mem_write;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.aluop         = ctl.aluop;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.illegal       = ctl.illegal;
  assign bus.state         = state_q;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: the driver walks each instruction
// through its state path and queues the expected per-cycle outputs; a monitor compares.
module tb_multicycle_main_control;
  localparam int CW = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic [3:0]    st;
    ctl_t          ctl;
    logic [CW-1:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  exp_t sb[$];
  logic [CW-1:0] model_ret = '0;

  multicycle_main_control_if #(.CNT_W(CW)) bus ();
  multicycle_main_control #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Expected control word for one cycle, from the per-state output table.
  function automatic ctl_t exp_ctl(input int st, input logic mr, input logic ill, input logic r);
    ctl_t c = '0;
    if (!r) return c;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  begin c.alu_src_b = 2'b11; c.illegal = ill; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.i_or_d = 1; end
      6:  begin c.alu_src_a = 1; c.aluop = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.aluop = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock of stimulus; queues what the DUT must show during this cycle.
  task automatic cycle(input logic r, input logic [5:0] op, input logic mr,
                       input int st, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    bus.opcode = op;
    bus.mem_ready = mr;
    e.st  = 4'(st);
    e.ctl = exp_ctl(st, mr, ill, r);
    e.ret = model_ret;
    sb.push_back(e);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    for (int i = 0; i < sf; i++) cycle(1, op, 0, 0, 0);
    cycle(1, op, 1, 0, 0);
    cycle(1, op, rnd_bit(), 1, !legal(op));
    if (!legal(op)) return;
    case (op)
      6'b000000: begin cycle(1, op, rnd_bit(), 6, 0); cycle(1, op, rnd_bit(), 7, 0); end
      6'b100011: begin
        cycle(1, op, rnd_bit(), 2, 0);
        for (int i = 0; i < sm; i++) cycle(1, op, 0, 3, 0);
        cycle(1, op, 1, 3, 0);
        cycle(1, op, rnd_bit(), 4, 0);
      end
      6'b101011: begin
        cycle(1, op, rnd_bit(), 2, 0);
        for (int i = 0; i < sm; i++) cycle(1, op, 0, 5, 0);
        cycle(1, op, 1, 5, 0);
      end
      6'b000100: cycle(1, op, rnd_bit(), 8, 0);
      6'b000010: cycle(1, op, rnd_bit(), 9, 0);
      default: begin cycle(1, op, rnd_bit(), 10, 0); cycle(1, op, rnd_bit(), 11, 0); end
    endcase
    model_ret = model_ret + 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    ctl_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.aluop, bus.pc_source, bus.illegal};
        chk("state", 32'(bus.state), 32'(e.st));
        chk("ctl", 32'(a), 32'(e.ctl));
        chk("retired", 32'(bus.retired), 32'(e.ret));
      end
    end
  end

  initial begin : driver
    logic [5:0] ops [7];
    int idx;
    bus.opcode = '0;
    bus.mem_ready = 1'b1;
    cycle(0, 6'd0, 1, 0, 0);
    cycle(0, 6'd0, 1, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 1, 0);
    // sw interrupted by reset while stalled in MEMWR
    cycle(1, 6'b101011, 1, 0, 0);
    cycle(1, 6'b101011, 0, 1, 0);
    cycle(1, 6'b101011, 0, 2, 0);
    cycle(1, 6'b101011, 0, 5, 0);
    cycle(0, 6'b101011, 1, 5, 0);
    model_ret = '0;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 6);
      if (idx == 6) ops[6] = 6'($urandom);
      run_instr(ops[idx], $urandom_range(0, 2), $urandom_range(0, 3));
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
